// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId,
// exception and interrupt acceptance, handler redirect and eret return PC.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID         = 32'h0000_2024,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // EXL is carried by the FSM state.
  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_IN_HANDLER = 1'b1
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic        exl_s;
  logic [5:0]  im_r;
  logic        ie_r;
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  logic [31:0] epc_r;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic [31:0] epc_exc_s;

  assign exl_s      = (state_r == ST_IN_HANDLER);
  assign sr_wr_s    = we & (addr == ADDR_SR) & ~req_s;
  assign epc_wr_s   = we & (addr == ADDR_EPC) & ~req_s;
  assign epc_exc_s  = bd_in ? (vpc - 32'd4) : vpc;
  assign handler_pc = HANDLER_ADDR;
  assign req        = req_s;

  // State register: NORMAL / IN_HANDLER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: accepted request beats eret, eret beats an mtc0 to SR.
  always_comb begin
    state_nxt_s = state_r;
    if (req_s) begin
      state_nxt_s = ST_IN_HANDLER;
    end else if (eret) begin
      state_nxt_s = ST_NORMAL;
    end else if (sr_wr_s) begin
      state_nxt_s = wdata[1] ? ST_IN_HANDLER : ST_NORMAL;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Request decode; interrupts use the live lines, and reset masks everything.
  always_comb begin
    int_req_s = 1'b0;
    exc_req_s = 1'b0;
    if (!exl_s) begin
      int_req_s = ie_r & (|(hw_int & im_r));
      exc_req_s = (exc_code_in != 5'd0);
    end else begin
      int_req_s = 1'b0;
      exc_req_s = 1'b0;
    end
    req_s = reset & (int_req_s | exc_req_s);
  end

  // SR IM/IE: mtc0 writable unless a request claims the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_r <= 6'd0;
      ie_r <= 1'b0;
    end else if (sr_wr_s) begin
      im_r <= wdata[15:10];
      ie_r <= wdata[0];
    end else begin
      im_r <= im_r;
      ie_r <= ie_r;
    end
  end

  // Cause: IP tracks hw_int each cycle, BD/ExcCode captured on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip_r       <= 6'd0;
      bd_r       <= 1'b0;
      exc_code_r <= 5'd0;
    end else if (req_s) begin
      ip_r       <= hw_int;
      bd_r       <= bd_in;
      exc_code_r <= int_req_s ? 5'd0 : exc_code_in;
    end else begin
      ip_r       <= hw_int;
      bd_r       <= bd_r;
      exc_code_r <= exc_code_r;
    end
  end

  // EPC: faulting PC (minus 4 in a delay slot) on acceptance, else mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_r <= 32'd0;
    end else if (req_s) begin
      epc_r <= epc_exc_s;
    end else if (epc_wr_s) begin
      epc_r <= wdata;
    end else begin
      epc_r <= epc_r;
    end
  end

  // Forward an in-flight mtc0 EPC so a following eret needs no stall.
  always_comb begin
    if (we && (addr == ADDR_EPC)) begin
      epc_out = wdata;
    end else begin
      epc_out = epc_r;
    end
  end

  // mfc0 read mux.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_SR:    rdata = {16'd0, im_r, 8'd0, exl_s, ie_r};
      ADDR_CAUSE: rdata = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      ADDR_EPC:   rdata = epc_r;
      ADDR_PRID:  rdata = PRID;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized self-checking bench for cp0_exc_ctrl against a word-level CP0 model,
// plus directed scenarios pinned with literal expectations.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID_C    = 32'h0000_2024;
  localparam logic [31:0] HANDLER_C = 32'h0000_4180;
  localparam logic [31:0] SR_MASK   = 32'h0000_FC03;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int), .eret(eret),
    .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] n_sr, n_cause, n_epc;
  logic        m_ireq, m_ereq, exp_req;
  logic [31:0] exp_rdata, exp_epc_out;

  always_comb begin
    m_ireq = (m_sr[1] == 1'b0) && (m_sr[0] == 1'b1) && ((hw_int & m_sr[15:10]) != 6'd0);
    m_ereq = (m_sr[1] == 1'b0) && (exc_code_in != 5'd0);
    exp_req = reset && (m_ireq || m_ereq);
    exp_epc_out = (we && addr == 5'd14) ? wdata : m_epc;
    if (addr == 5'd12)      exp_rdata = m_sr;
    else if (addr == 5'd13) exp_rdata = m_cause;
    else if (addr == 5'd14) exp_rdata = m_epc;
    else if (addr == 5'd15) exp_rdata = PRID_C;
    else                    exp_rdata = 32'd0;
    n_sr    = m_sr;
    n_epc   = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
    if (exp_req) begin
      n_sr    = m_sr | 32'h2;
      n_cause = ({26'd0, hw_int} << 10) | ({31'd0, bd_in} << 31)
              | ({27'd0, (m_ireq ? 5'd0 : exc_code_in)} << 2);
      n_epc   = bd_in ? vpc - 32'd4 : vpc;
    end else begin
      if (we && addr == 5'd12) n_sr = wdata & SR_MASK;
      if (we && addr == 5'd14) n_epc = wdata;
      if (eret) n_sr = n_sr & ~32'h2;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr <= 32'd0; m_cause <= 32'd0; m_epc <= 32'd0;
    end else begin
      m_sr <= n_sr; m_cause <= n_cause; m_epc <= n_epc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req", {31'd0, req}, {31'd0, exp_req});
      check("rdata", rdata, exp_rdata);
      check("epc_out", epc_out, exp_epc_out);
      check("handler_pc", handler_pc, HANDLER_C);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                       input logic [5:0] hw, input logic er);
    we = w; addr = a; wdata = wd; vpc = pc; bd_in = bd; exc_code_in = ec; hw_int = hw; eret = er;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
    we = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  logic [4:0] exc_tab [4] = '{5'd4, 5'd5, 5'd10, 5'd12};
  logic [4:0] ra;

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick(); tick();
    chk_en = 1'b1;
    peek(5'd12, 32'd0, "rst_sr");
    peek(5'd13, 32'd0, "rst_cause");
    peek(5'd14, 32'd0, "rst_epc");
    reset = 1'b1;
    tick();
    peek(5'd15, PRID_C, "prid");
    peek(5'd7, 32'd0, "unmapped");
    // Overflow exception outside a delay slot.
    drive(1'b0, 5'd0, 32'd0, 32'h3010, 1'b0, 5'd12, 6'd0, 1'b0);
    #1; check("ov_req", {31'd0, req}, 32'd1);
    tick();
    peek(5'd14, 32'h3010, "ov_epc");
    peek(5'd13, 32'h0000_0030, "ov_cause");
    peek(5'd12, 32'h0000_0002, "ov_sr");
    // Masked while EXL, then eret.
    drive(1'b0, 5'd0, 32'd0, 32'h3014, 1'b0, 5'd10, 6'd0, 1'b0);
    #1; check("exl_req", {31'd0, req}, 32'd0);
    tick();
    peek(5'd13, 32'h0000_0030, "exl_cause");
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    peek(5'd12, 32'd0, "eret_sr");
    // Unaligned delay-slot fetch fault.
    drive(1'b0, 5'd0, 32'd0, 32'h3021, 1'b1, 5'd4, 6'd0, 1'b0);
    tick();
    peek(5'd14, 32'h0000_301D, "bd_epc");
    peek(5'd13, 32'h8000_0010, "bd_cause");
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    // Interrupt beats a simultaneous exception.
    drive(1'b1, 5'd12, 32'h0000_0401, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    peek(5'd12, 32'h0000_0401, "mtc0_sr");
    drive(1'b0, 5'd0, 32'd0, 32'h3030, 1'b0, 5'd5, 6'b000001, 1'b0);
    #1; check("int_req", {31'd0, req}, 32'd1);
    tick();
    peek(5'd13, 32'h0000_0400, "int_cause");
    peek(5'd12, 32'h0000_0403, "int_sr");
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
    tick();
    // Request discards a same-edge mtc0.
    drive(1'b1, 5'd12, 32'h0000_FC00, 32'h100, 1'b0, 5'd12, 6'd0, 1'b0);
    tick();
    peek(5'd12, 32'h0000_0403, "req_vs_we");
    // mtc0 EPC together with eret.
    drive(1'b1, 5'd14, 32'h4000, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
    #1; check("fwd_epc_out", epc_out, 32'h4000);
    tick();
    peek(5'd14, 32'h4000, "fwd_epc");
    peek(5'd12, 32'h0000_0401, "fwd_sr");
    // Asynchronous reset while in the handler.
    drive(1'b0, 5'd0, 32'd0, 32'h3008, 1'b0, 5'd12, 6'd0, 1'b0);
    tick();
    exc_code_in = 5'd12;
    reset = 1'b0;
    #1; check("arst_req", {31'd0, req}, 32'd0);
    peek(5'd12, 32'd0, "arst_sr");
    peek(5'd13, 32'd0, "arst_cause");
    peek(5'd14, 32'd0, "arst_epc");
    tick();
    reset = 1'b1;
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 5'd12;
        1: ra = 5'd13;
        2: ra = 5'd14;
        3: ra = 5'd15;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      drive(($urandom_range(0, 9) < 2), ra, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3) ? exc_tab[$urandom_range(0, 3)] : 5'd0,
            ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom),
            ($urandom_range(0, 99) < 15));
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
